// File: rtl/ccw_sequencer.sv
// Channel command word sequencer: drives one CCW through a channel and bridges the data streams.
// Optional watchdog selected by CCW_SEQUENCER_TIMEOUT_EN (undefined: no watchdog, host_timeout tied low).
module ccw_sequencer #(
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             host_addr,
    input  logic [7:0]             host_command,
    input  logic [COUNT_WIDTH-1:0] host_count,
    input  logic                   host_go,
    output logic                   host_busy,
    output logic                   host_done,
    output logic [1:0]             host_cc,
    output logic [7:0]             host_status,
    output logic [COUNT_WIDTH-1:0] host_residual,
    output logic                   host_timeout,
    input  logic [7:0]             host_tx_tdata,
    input  logic                   host_tx_tvalid,
    output logic                   host_tx_tready,
    output logic [7:0]             host_rx_tdata,
    output logic                   host_rx_tvalid,
    input  logic                   host_rx_tready,
    output logic [7:0]             chan_addr,
    output logic [7:0]             chan_command,
    output logic                   chan_start,
    output logic                   chan_stop,
    input  logic                   chan_active,
    input  logic [1:0]             chan_condition_code,
    input  logic [7:0]             chan_status_tdata,
    input  logic                   chan_status_tvalid,
    output logic [7:0]             chan_send_tdata,
    output logic                   chan_send_tvalid,
    input  logic                   chan_send_tready,
    input  logic [7:0]             chan_recv_tdata,
    input  logic                   chan_recv_tvalid,
    output logic                   chan_recv_tready
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACTIVE,
        RUN,
        STOP,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] residual_q, residual_d;
    logic [7:0]             chanAddr_q, chanAddr_d;
    logic [7:0]             chanCommand_q, chanCommand_d;
    logic [1:0]             hostCc_q, hostCc_d;
    logic [7:0]             hostStatus_q, hostStatus_d;
    logic [COUNT_WIDTH-1:0] hostResidual_q, hostResidual_d;
    logic                   hostTimeout_q, hostTimeout_d;

    logic                   isSend;
    logic                   xferEn;
    logic                   handshake;
    logic [COUNT_WIDTH-1:0] residualNext;
    logic                   wdFire;

    // Streams are only bridged while running with bytes still owed; otherwise both sides see backpressure.
    always_comb begin
        isSend           = chanCommand_q[0];
        xferEn           = (state_q == RUN) && (residual_q != '0);
        chan_send_tdata  = host_tx_tdata;
        chan_send_tvalid = xferEn && isSend && host_tx_tvalid;
        host_tx_tready   = xferEn && isSend && chan_send_tready;
        host_rx_tdata    = chan_recv_tdata;
        host_rx_tvalid   = xferEn && !isSend && chan_recv_tvalid;
        chan_recv_tready = xferEn && !isSend && host_rx_tready;
        handshake        = (chan_send_tvalid && chan_send_tready) ||
                           (chan_recv_tvalid && chan_recv_tready);
        residualNext     = handshake ? (residual_q - COUNT_WIDTH'(1)) : residual_q;
    end

`ifdef CCW_SEQUENCER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            wdWindow;

    // The watchdog restarts as the channel is started and runs until the operation completes.
    always_comb begin
        wdWindow = (state_q == WAIT_ACTIVE) || (state_q == RUN) || (state_q == STOP);
        wdFire   = wdWindow && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
        wd_d     = wd_q;
        if (state_q == START) begin
            wd_d = '0;
        end else if (wdWindow) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign host_timeout = hostTimeout_q;
`else
    logic unusedTimeoutCfg;

    assign unusedTimeoutCfg = ^TIMEOUT_CYCLES ^ hostTimeout_q;
    assign wdFire           = 1'b0;
    assign host_timeout     = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        residual_d     = residual_q;
        chanAddr_d     = chanAddr_q;
        chanCommand_d  = chanCommand_q;
        hostCc_d       = hostCc_q;
        hostStatus_d   = hostStatus_q;
        hostResidual_d = hostResidual_q;
        hostTimeout_d  = hostTimeout_q;

        case (state_q)
            IDLE: begin
                if (host_go) begin
                    chanAddr_d    = host_addr;
                    chanCommand_d = host_command;
                    residual_d    = host_count;
                    hostTimeout_d = 1'b0;
                    state_d       = START;
                end
            end
            START: begin
                state_d = WAIT_ACTIVE;
            end
            WAIT_ACTIVE: begin
                if (chan_active) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A byte accepted in the same cycle the channel drops still counts.
                residual_d = residualNext;
                if (!chan_active) begin
                    hostCc_d = chan_condition_code;
                    state_d  = DONE;
                end else if (residual_q == '0) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (!chan_active) begin
                    hostCc_d = chan_condition_code;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wdFire) begin
            hostCc_d      = 2'd3;
            hostTimeout_d = 1'b1;
            state_d       = DONE;
        end

        if ((state_d == DONE) && (state_q != DONE)) begin
            hostResidual_d = residual_d;
        end

        if ((state_q != IDLE) && chan_status_tvalid) begin
            hostStatus_d = chan_status_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            residual_q     <= '0;
            chanAddr_q     <= '0;
            chanCommand_q  <= '0;
            hostCc_q       <= '0;
            hostStatus_q   <= '0;
            hostResidual_q <= '0;
            hostTimeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            residual_q     <= residual_d;
            chanAddr_q     <= chanAddr_d;
            chanCommand_q  <= chanCommand_d;
            hostCc_q       <= hostCc_d;
            hostStatus_q   <= hostStatus_d;
            hostResidual_q <= hostResidual_d;
            hostTimeout_q  <= hostTimeout_d;
        end
    end

    assign host_busy     = (state_q != IDLE);
    assign host_done     = (state_q == DONE);
    assign chan_start    = (state_q == START);
    assign chan_stop     = (state_q == STOP);
    assign chan_addr     = chanAddr_q;
    assign chan_command  = chanCommand_q;
    assign host_cc       = hostCc_q;
    assign host_status   = hostStatus_q;
    assign host_residual = hostResidual_q;

endmodule

// File: doc/ccw_sequencer.md
CCW_SEQUENCER -- requirements
Module: ccw_sequencer

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16, width of byte count and residual.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000000, watchdog limit in clk cycles (used only under REQ-031).
REQ-003 SHALL have ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- host_addr  in  8  device address.
- host_command  in  8  CCW command; bit0=1 means send (write/control), 0 means receive.
- host_count  in  COUNT_WIDTH  byte count.
- host_go  in  1  start request.
- host_busy  out  1  operation in progress.
- host_done  out  1  one-cycle completion pulse.
- host_cc  out  2  final condition code.
- host_status  out  8  last status byte.
- host_residual  out  COUNT_WIDTH  bytes not transferred.
- host_timeout  out  1  watchdog fired.
- host_tx_tdata/tvalid/tready  in/in/out  8/1/1  host send stream.
- host_rx_tdata/tvalid/tready  out/out/in  8/1/1  host receive stream.
- chan_addr, chan_command  out  8 each  to channel.
- chan_start, chan_stop  out  1 each  to channel.
- chan_active  in  1  channel subchannel active.
- chan_condition_code  in  2  channel condition code.
- chan_status_tdata/tvalid  in  8/1  channel status stream.
- chan_send_tdata/tvalid/tready  out/out/in  8/1/1  channel send stream.
- chan_recv_tdata/tvalid/tready  in/in/out  8/1/1  channel receive stream.

Function
REQ-004 SHALL implement states IDLE, START, WAIT_ACTIVE, RUN, STOP, DONE; host_busy = (state != IDLE).
REQ-005 IDLE: on host_go=1, latch addr/command into chan_addr/chan_command and count into residual, clear host_timeout, go to START.
REQ-006 host_go while busy SHALL be ignored; latched values SHALL hold constant until IDLE.
REQ-007 START: chan_start=1 for exactly one cycle, then WAIT_ACTIVE.
REQ-008 WAIT_ACTIVE: on chan_active=1 go to RUN.
REQ-009 RUN: if chan_active=0, go to DONE; else if residual=0, go to STOP.
REQ-010 Send (command bit0=1), residual>0, state RUN: chan_send_tdata=host_tx_tdata, chan_send_tvalid=host_tx_tvalid, host_tx_tready=chan_send_tready (combinational pass-through).
REQ-011 Receive (bit0=0), residual>0, state RUN: host_rx_tdata=chan_recv_tdata, host_rx_tvalid=chan_recv_tvalid, chan_recv_tready=host_rx_tready.
REQ-012 Outside REQ-010/011 conditions, host_tx_tready, chan_send_tvalid, host_rx_tvalid, chan_recv_tready SHALL be 0.
REQ-013 Each channel-side handshake (tvalid&tready) SHALL decrement residual by 1; residual SHALL never wrap below 0.
REQ-014 STOP: hold chan_stop=1; on chan_active=0 go to DONE.
REQ-015 Every chan_status_tvalid=1 in any non-IDLE state SHALL load host_status; the last one wins.
REQ-016 DONE: host_done=1 for one cycle; latch host_cc=chan_condition_code; host_residual=residual; next state IDLE.
REQ-017 host_count=0 SHALL proceed WAIT_ACTIVE -> RUN -> STOP with no data transferred.
REQ-018 If the channel goes inactive with residual>0 (short transfer, cc=3, busy), the block SHALL go to DONE and report nonzero residual.
REQ-019 Handshake and chan_active=0 in the same cycle: the decrement SHALL count, and DONE SHALL report the decremented residual.
REQ-020 host_cc, host_status, host_residual, host_timeout SHALL hold until the next accepted host_go.

Reset
REQ-021 reset SHALL force IDLE, chan_start=0, chan_stop=0, host_done=0, host_timeout=0, host_cc=0, host_status=0, host_residual=0, residual=0, chan_addr=0, chan_command=0, watchdog=0.
REQ-022 Reset mid-operation SHALL abort without a host_done pulse; all stream valid/ready outputs SHALL be 0 in the following cycle.

Configuration
REQ-030 Macro CCW_SEQUENCER_TIMEOUT_EN SHALL select the watchdog.
REQ-031 Defined: a counter SHALL clear on entry to WAIT_ACTIVE and increment in WAIT_ACTIVE/RUN/STOP; on reaching TIMEOUT_CYCLES the block SHALL go to DONE with host_timeout=1 and host_cc=3.
REQ-032 Undefined: no counter logic; host_timeout SHALL be tied 0.

Verification
REQ-040 Send: addr=0x10, cmd=0x01, count=3, bytes 0xAA,0xBB,0xCC, then status 0x0C and active falls -> three chan handshakes; one chan_stop episode; host_done with residual=0, host_status=0x0C.
REQ-041 Receive: cmd=0x02, count=2, channel offers 4 bytes -> host gets exactly 2 bytes; chan_recv_tready=0 for byte 3; chan_stop asserted; residual=0.
REQ-042 Not operational: chan_active pulses 2 cycles then cc=3 -> host_done, host_cc=3, residual=count=5, no stream handshakes.
REQ-043 Reset asserted in RUN with residual=2 -> IDLE next cycle; host_busy=0; no host_done; chan_stop=0.
REQ-044 With CCW_SEQUENCER_TIMEOUT_EN and TIMEOUT_CYCLES=20, chan_active stuck at 1 -> host_done within 22 cycles of chan_start; host_timeout=1; host_cc=3.
REQ-045 host_go pulsed during RUN with different addr -> ignored; chan_addr unchanged.
